tdm_demux: RTL and testbench

//   1-to-8 time-division demultiplexer: the receive end of the 8:1 mux link.
//   A serial bit stream carries one bit per channel, channel 0 first; a sync

---
 rtl/tdm_demux_if.sv | 24 ++
 rtl/tdm_demux.sv | 100 ++++++++++
 tb/tb_tdm_demux.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tdm_demux_if.sv
// tdm_demux_if -- serial-in / frame-out bundle for the 1:NCH TDM demux.
//   en    : sample strobe, din/sync valid this cycle
//   sync  : frame marker, high with en on the channel-0 bit
//   din   : serial data bit
//   s     : current channel select (next lane to be written)
//   y     : last complete frame, y[k] = channel k
//   valid : one-cycle pulse, y just updated
//   err   : one-cycle pulse, sync seen mid-frame
// master = stream source / frame consumer, slave = the demux.
interface tdm_demux_if #(
  parameter int NCH = 8,
  parameter int SW  = 3
);
  logic           en;
  logic           sync;
  logic           din;
  logic [SW-1:0]  s;
  logic [NCH-1:0] y;
  logic           valid;
  logic           err;

  modport master (output en, sync, din, input s, y, valid, err);
  modport slave  (input en, sync, din, output s, y, valid, err);
endinterface

// File: rtl/tdm_demux.sv
// tdm_demux -- receive end of the NCH:1 TDM link.
//   Collects one en-qualified bit per channel (channel 0 first, marked by
//   sync), then presents the whole frame on y with a one-cycle valid pulse.
//   A sync arriving mid-frame drops the partial frame, pulses err and
//   restarts the frame with that bit.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous reset, active-high
//   bus : tdm_demux_if.slave (en/sync/din in; s/y/valid/err out)
module tdm_demux #(
  parameter int NCH = 8,
  parameter int SW  = 3
) (
  input  logic        clk,
  input  logic        rst,
  tdm_demux_if.slave  bus
);

  localparam logic [SW-1:0] LAST = SW'(NCH - 1);

  typedef enum logic {HUNT, RUN} state_t;

  state_t         r_state, w_state;
  logic [SW-1:0]  r_s, w_s;
  // The last lane is never stored: it goes straight into y with the frame.
  logic [NCH-2:0] r_shadow, w_shadow;
  logic [NCH-1:0] r_y, w_y;
  logic           r_valid, w_valid;
  logic           r_err, w_err;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= HUNT;
      r_s      <= '0;
      r_shadow <= '0;
      r_y      <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_s      <= w_s;
      r_shadow <= w_shadow;
      r_y      <= w_y;
      r_valid  <= w_valid;
      r_err    <= w_err;
    end
  end

  // Next-state logic
  always_comb begin
    w_state  = r_state;
    w_s      = r_s;
    w_shadow = r_shadow;
    w_y      = r_y;
    w_valid  = 1'b0;
    w_err    = 1'b0;
    unique case (r_state)
      HUNT: begin
        if (bus.en && bus.sync) begin
          w_shadow    = '0;
          w_shadow[0] = bus.din;
          w_s         = SW'(1);
          w_state     = RUN;
        end
      end
      RUN: begin
        if (bus.en) begin
          // sync is checked first so that sync on the last lane is an
          // error rather than a completion.
          if (bus.sync && (r_s != '0)) begin
            w_err       = 1'b1;
            w_shadow    = '0;
            w_shadow[0] = bus.din;
            w_s         = SW'(1);
          end else if (r_s == LAST) begin
            w_y      = {bus.din, r_shadow};
            w_valid  = 1'b1;
            w_shadow = '0;
            w_s      = '0;
          end else begin
            // Covers s==0 with or without sync: lock is free-running.
            w_shadow[r_s] = bus.din;
            w_s           = r_s + SW'(1);
          end
        end
      end
      default: w_state = HUNT;
    endcase
  end

  // Outputs
  always_comb begin
    bus.s     = r_s;
    bus.y     = r_y;
    bus.valid = r_valid;
    bus.err   = r_err;
  end

endmodule

// File: tb/tb_tdm_demux.sv
module tb_tdm_demux;

  localparam int NCH = 8;
  localparam int SW  = 3;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  logic [NCH-1:0] sb_q[$];   // expected frames, pushed as the last bit is driven
  int             vcyc_q[$]; // cycle stamps of observed valid pulses

  tdm_demux_if #(.NCH(NCH), .SW(SW)) bus ();

  tdm_demux #(.NCH(NCH), .SW(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every valid pulse must match the next expected frame.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.valid === 1'b1) begin
      logic [NCH-1:0] exp_y;
      vcyc_q.push_back(cyc);
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_valid: got y=%h, expected no valid", bus.y);
      end else begin
        exp_y = sb_q.pop_front();
        if (bus.y !== exp_y) begin
          errors++;
          $display("FAIL sb_frame: got y=%h, expected %h", bus.y, exp_y);
        end
      end
    end
  end

  task automatic drive(input logic e, input logic sy, input logic d);
    @(negedge clk);
    bus.en = e; bus.sync = sy; bus.din = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0);
  endtask

  // Sends a whole frame LSB first, en continuously high, optional sync on bit 0.
  task automatic send_frame(input logic [NCH-1:0] v, input logic with_sync);
    for (int i = 0; i < NCH; i++) begin
      if (i == NCH - 1) sb_q.push_back(v);
      drive(1'b1, with_sync && (i == 0), v[i]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0; bus.sync = 1'b0; bus.din = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.s !== 3'd0 || bus.y !== 8'h00 || bus.valid !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got s=%0d y=%h valid=%b err=%b, expected 0 00 0 0",
               bus.s, bus.y, bus.valid, bus.err);
    end
    rst = 1'b0;
    // HUNT: bits without sync are discarded
    for (int i = 0; i < 6; i++) begin
      drive(i[0], 1'b0, ~i[1]);
      @(negedge clk);
      checks++;
      if (bus.s !== 3'd0 || bus.valid !== 1'b0) begin
        errors++;
        $display("FAIL hunt_hold: got s=%0d valid=%b, expected s=0 valid=0", bus.s, bus.valid);
      end
    end
  endtask

  task automatic test_single_frame();
    send_frame(8'h21, 1'b1);
    idle();
    checks++;
    if (bus.valid !== 1'b1 || bus.y !== 8'h21 || bus.s !== 3'd0) begin
      errors++;
      $display("FAIL single_frame: got valid=%b y=%h s=%0d, expected 1 21 0",
               bus.valid, bus.y, bus.s);
    end
    idle();
    checks++;
    if (bus.valid !== 1'b0 || bus.y !== 8'h21) begin
      errors++;
      $display("FAIL single_pulse: got valid=%b y=%h, expected 0 21", bus.valid, bus.y);
    end
  endtask

  task automatic test_back_to_back();
    vcyc_q.delete();
    send_frame(8'h05, 1'b1);
    send_frame(8'hC1, 1'b0);
    idle();
    idle();
    checks++;
    if (vcyc_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d valid pulses, expected 2", vcyc_q.size());
    end else begin
      checks++;
      if (vcyc_q[1] - vcyc_q[0] != NCH) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d cycles, expected %0d", vcyc_q[1] - vcyc_q[0], NCH);
      end
    end
    checks++;
    if (bus.y !== 8'hC1) begin
      errors++;
      $display("FAIL b2b_final_y: got %h, expected c1", bus.y);
    end
  endtask

  task automatic test_en_gaps();
    logic [NCH-1:0] v;
    logic [SW-1:0]  s_hold;
    v = 8'h81;
    vcyc_q.delete();
    for (int i = 0; i < NCH; i++) begin
      if (i == NCH - 1) sb_q.push_back(v);
      drive(1'b1, i == 0, v[i]);
      idle();
      s_hold = bus.s;
      if (i < NCH - 1) begin
        idle();
        checks++;
        if (bus.s !== s_hold || bus.s !== SW'(i + 1)) begin
          errors++;
          $display("FAIL gap_s_frozen: got s=%0d, expected %0d", bus.s, i + 1);
        end
      end
    end
    idle();
    checks++;
    if (vcyc_q.size() != 1 || bus.y !== 8'h81) begin
      errors++;
      $display("FAIL gap_frame: got %0d pulses y=%h, expected 1 pulse y=81", vcyc_q.size(), bus.y);
    end
  endtask

  task automatic test_framing_error();
    logic [NCH-1:0] v;
    v = 8'h61;
    send_frame(8'h09, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    idle();
    checks++;
    if (bus.s !== 3'd3 || bus.y !== 8'h09) begin
      errors++;
      $display("FAIL ferr_setup: got s=%0d y=%h, expected 3 09", bus.s, bus.y);
    end
    drive(1'b1, 1'b1, v[0]);
    idle();
    checks++;
    if (bus.err !== 1'b1 || bus.valid !== 1'b0 || bus.y !== 8'h09 || bus.s !== 3'd1) begin
      errors++;
      $display("FAIL ferr_pulse: got err=%b valid=%b y=%h s=%0d, expected 1 0 09 1",
               bus.err, bus.valid, bus.y, bus.s);
    end
    idle();
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL ferr_one_cycle: got err=%b, expected 0", bus.err);
    end
    for (int i = 1; i < NCH; i++) begin
      if (i == NCH - 1) sb_q.push_back(v);
      drive(1'b1, 1'b0, v[i]);
    end
    idle();
    checks++;
    if (bus.valid !== 1'b1 || bus.y !== 8'h61 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL ferr_recover: got valid=%b y=%h err=%b, expected 1 61 0",
               bus.valid, bus.y, bus.err);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [NCH-1:0] v;
    v = 8'h07;
    for (int i = 0; i < 5; i++) drive(1'b1, i == 0, v[i]);
    idle();
    checks++;
    if (bus.s !== 3'd5) begin
      errors++;
      $display("FAIL midrst_setup: got s=%0d, expected 5", bus.s);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.s !== 3'd0 || bus.y !== 8'h00 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: got s=%0d y=%h valid=%b, expected 0 00 0",
               bus.s, bus.y, bus.valid);
    end
    for (int i = 0; i < NCH; i++) drive(1'b1, 1'b0, 1'b1);
    idle();
    checks++;
    if (bus.s !== 3'd0 || bus.y !== 8'h00) begin
      errors++;
      $display("FAIL midrst_hunt: got s=%0d y=%h, expected 0 00", bus.s, bus.y);
    end
    send_frame(8'hA5, 1'b1);
    idle();
    checks++;
    if (bus.y !== 8'hA5) begin
      errors++;
      $display("FAIL midrst_relock: got y=%h, expected a5", bus.y);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_en_gaps();
    test_framing_error();
    test_reset_mid_frame();
    repeat (2) idle();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d frames never seen, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
